// File: rtl/if_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_if
// Bundle between the instruction-fetch front end and its surroundings
// (EX redirect, decode handshake, BIOS/IMEM synchronous-read ports,
// fault report and performance counters).
//
// Modports:
//   master : the fetch unit (drives PC-derived addresses and decode outputs)
//   slave  : the environment (EX stage, decode, memories)
//
// Signals:
//   redirect, redirect_target    EX branch/jump request and target PC
//   out_ready / out_valid        decode handshake
//   instruction                  presented instruction (NOP on flush)
//   instruction_raw              memory data before the flush mux
//   pc_out                       PC of the presented instruction
//   bios_addr / bios_data        BIOS word address / 1-cycle read data
//   imem_addr / imem_data        IMEM word address / 1-cycle read data
//   fetch_fault / fault_pc       sticky fault flag and first faulting PC
//   fetch_count / flush_count    accepted / redirect-cycle counters
// -----------------------------------------------------------------------------
interface if_fetch_unit_if #(
   parameter int unsigned BIOS_AW = 12,
   parameter int unsigned IMEM_AW = 14
);
   logic               redirect;
   logic [31:0]        redirect_target;
   logic               out_ready;
   logic               out_valid;
   logic [31:0]        instruction;
   logic [31:0]        instruction_raw;
   logic [31:0]        pc_out;
   logic [BIOS_AW-1:0] bios_addr;
   logic [31:0]        bios_data;
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_data;
   logic               fetch_fault;
   logic [31:0]        fault_pc;
   logic [31:0]        fetch_count;
   logic [31:0]        flush_count;

   modport master (
      input  redirect, redirect_target, out_ready, bios_data, imem_data,
      output out_valid, instruction, instruction_raw, pc_out,
             bios_addr, imem_addr, fetch_fault, fault_pc,
             fetch_count, flush_count
   );

   modport slave (
      output redirect, redirect_target, out_ready, bios_data, imem_data,
      input  out_valid, instruction, instruction_raw, pc_out,
             bios_addr, imem_addr, fetch_fault, fault_pc,
             fetch_count, flush_count
   );
endinterface

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch front end for the 3-stage RISC-V pipeline. Owns the PC,
// issues word addresses to the BIOS and IMEM synchronous-read memories
// (selected by PC[31:28]), presents instructions to decode with a
// valid/ready handshake, holds the address on stall, emits a NOP bubble on
// redirect and latches the first misaligned/unmapped fetch address.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : if_fetch_unit_if.master (redirect, decode handshake, memory
//          address/data, fault report, counters)
//
// Optional feature: define IF_PERF_CNT_EN to implement the 32-bit wrapping
// fetch_count/flush_count counters; otherwise both read 0 and no counter
// flops exist.
// -----------------------------------------------------------------------------
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h4000_0000,
   parameter int unsigned BIOS_AW     = 12,
   parameter int unsigned IMEM_AW     = 14,
   parameter logic [3:0]  BIOS_REGION = 4'h4,
   parameter logic [3:0]  IMEM_REGION = 4'h1,
   parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
   input logic             clk,
   input logic             rst,
   if_fetch_unit_if.master bus
);

   typedef enum logic {ST_BOOT, ST_RUN} state_e;
   typedef enum logic {SRC_BIOS, SRC_IMEM} src_e;

   state_e      state_q;
   src_e        src_q;
   src_e        src_d;
   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic        fault_q;
   logic [31:0] fault_pc_q;

   logic        out_valid;
   logic        accept;
   logic        redirect_run;
   logic        region_ok;
   logic        misaligned;
   logic        fault_new;

   always_comb begin
      // Valid drops combinationally on redirect (flush) and from the cycle
      // after a fault is latched.
      out_valid    = (state_q == ST_RUN) && !bus.redirect && !fault_q;
      accept       = out_valid && bus.out_ready;
      redirect_run = (state_q == ST_RUN) && bus.redirect;

      // A latched fault freezes the PC, overriding redirect.
      if (state_q == ST_BOOT)  pc_d = RESET_PC;
      else if (fault_q)        pc_d = pc_q;
      else if (bus.redirect)   pc_d = bus.redirect_target;
      else if (accept)         pc_d = pc_q + 32'd4;
      else                     pc_d = pc_q;

      region_ok  = (pc_d[31:28] == BIOS_REGION) || (pc_d[31:28] == IMEM_REGION);
      misaligned = redirect_run && !fault_q && (bus.redirect_target[1:0] != 2'b00);
      fault_new  = !fault_q && (misaligned || !region_ok);

      src_d = (pc_d[31:28] == IMEM_REGION) ? SRC_IMEM : SRC_BIOS;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_PC;
         src_q      <= SRC_BIOS;
         fault_q    <= 1'b0;
         fault_pc_q <= '0;
      end else begin
         state_q <= ST_RUN;
         pc_q    <= pc_d;
         src_q   <= src_d;
         if (fault_new) begin
            fault_q    <= 1'b1;
            fault_pc_q <= pc_d;
         end
      end
   end

   // Addresses come straight from next-PC so the 1-cycle memory read lines
   // up with pc_q in the following cycle.
   assign bus.bios_addr       = pc_d[BIOS_AW+1:2];
   assign bus.imem_addr       = pc_d[IMEM_AW+1:2];
   assign bus.instruction_raw = (src_q == SRC_IMEM) ? bus.imem_data : bus.bios_data;
   assign bus.instruction     = bus.redirect ? NOP_INST : bus.instruction_raw;
   assign bus.out_valid       = out_valid;
   assign bus.pc_out          = pc_q;
   assign bus.fetch_fault     = fault_q;
   assign bus.fault_pc        = fault_pc_q;

`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] flush_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (accept)       fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (redirect_run) flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign bus.fetch_count = fetch_cnt_q;
   assign bus.flush_count = flush_cnt_q;
`else
   assign bus.fetch_count = '0;
   assign bus.flush_count = '0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h4000_0000;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;
`ifdef IF_PERF_CNT_EN
   localparam logic [31:0] EXP_FETCH = 32'd10;
   localparam logic [31:0] EXP_FLUSH = 32'd2;
`else
   localparam logic [31:0] EXP_FETCH = 32'd0;
   localparam logic [31:0] EXP_FLUSH = 32'd0;
`endif

   logic clk;
   logic rst;

   if_fetch_unit_if #(.BIOS_AW(12), .IMEM_AW(14)) bus ();

   if_fetch_unit #(
      .RESET_PC    (RESET_PC),
      .BIOS_AW     (12),
      .IMEM_AW     (14),
      .BIOS_REGION (4'h4),
      .IMEM_REGION (4'h1),
      .NOP_INST    (NOP_INST)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents: BIOS word 0 is addi x1,x0,0; everything else is a
   // tagged word address so every fetch is distinguishable.
   function automatic logic [31:0] bios_word(input logic [11:0] a);
      return (a == 12'd0) ? 32'h0000_0093 : {20'hB1000, a};
   endfunction

   function automatic logic [31:0] imem_word(input logic [13:0] a);
      return {18'h2A000, a};
   endfunction

   always @(posedge clk) begin
      bus.bios_data <= bios_word(bus.bios_addr);
      bus.imem_data <= imem_word(bus.imem_addr);
   end

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   exp_t sb[$];

   task automatic push(input logic [31:0] pc, input logic [31:0] inst);
      exp_t e;
      e.pc   = pc;
      e.inst = inst;
      sb.push_back(e);
   endtask

   // Every accepted instruction must match the next scoreboard entry.
   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            check("acc_pc", bus.pc_out, e.pc);
            check("acc_inst", bus.instruction, e.inst);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst                 = 1'b1;
      bus.redirect        = 1'b0;
      bus.redirect_target = '0;
      bus.out_ready       = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_pc", bus.pc_out, RESET_PC);
      check("rst_fault", 32'(bus.fetch_fault), 32'd0);
      check("rst_fault_pc", bus.fault_pc, 32'd0);
      check("rst_fetch_cnt", bus.fetch_count, 32'd0);
      check("rst_flush_cnt", bus.flush_count, 32'd0);

      // Sequential fetch from BIOS
      push(32'h4000_0000, bios_word(12'd0));
      push(32'h4000_0004, bios_word(12'd1));
      push(32'h4000_0008, bios_word(12'd2));
      push(32'h4000_000C, bios_word(12'd3));
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("boot_valid", 32'(bus.out_valid), 32'd0);
      step();                       // 4000_0000
      step();                       // 4000_0004
      step();                       // 4000_0008
      bus.out_ready = 1'b0;

      // Stall for 3 cycles
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_pc", bus.pc_out, 32'h4000_0008);
         check("stall_inst", bus.instruction, bios_word(12'd2));
         check("stall_valid", 32'(bus.out_valid), 32'd1);
         check("stall_baddr", 32'(bus.bios_addr), 32'd2);
         step();
      end
      bus.out_ready = 1'b1;
      step();
      @(negedge clk);
      check("post_stall_pc", bus.pc_out, 32'h4000_000C);

      // Redirect into IMEM
      step();                       // 4000_0010, flushed
      bus.redirect        = 1'b1;
      bus.redirect_target = 32'h1000_0010;
      push(32'h1000_0010, imem_word(14'd4));
      push(32'h1000_0014, imem_word(14'd5));
      @(negedge clk);
      check("flush_inst", bus.instruction, NOP_INST);
      check("flush_valid", 32'(bus.out_valid), 32'd0);
      check("flush_raw", bus.instruction_raw, bios_word(12'd4));
      check("flush_iaddr", 32'(bus.imem_addr), 32'd4);
      step();
      bus.redirect = 1'b0;
      @(negedge clk);
      check("redir_pc", bus.pc_out, 32'h1000_0010);
      step();                       // 1000_0014
      step();                       // 1000_0018

      // Redirect during stall
      bus.out_ready       = 1'b0;
      bus.redirect        = 1'b1;
      bus.redirect_target = 32'h4000_0100;
      push(32'h4000_0100, bios_word(12'h040));
      push(32'h4000_0104, bios_word(12'h041));
      push(32'h4000_0108, bios_word(12'h042));
      push(32'h4000_010C, bios_word(12'h043));
      @(negedge clk);
      check("stall_redir_valid", 32'(bus.out_valid), 32'd0);
      check("stall_redir_inst", bus.instruction, NOP_INST);
      check("stall_redir_baddr", 32'(bus.bios_addr), 32'h40);
      step();
      bus.redirect  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("stall_redir_pc", bus.pc_out, 32'h4000_0100);
      step();                       // 0104
      step();                       // 0108
      step();                       // 010C
      step();                       // 0110
      bus.out_ready = 1'b0;
      @(negedge clk);
      check("fetch_count", bus.fetch_count, EXP_FETCH);
      check("flush_count", bus.flush_count, EXP_FLUSH);

      // Misaligned redirect then an unmapped one: first fault sticks
      step();
      bus.redirect        = 1'b1;
      bus.redirect_target = 32'h1000_0012;
      @(negedge clk);
      check("mis_valid", 32'(bus.out_valid), 32'd0);
      step();
      bus.redirect_target = 32'h2000_0000;
      @(negedge clk);
      check("fault_flag", 32'(bus.fetch_fault), 32'd1);
      check("fault_pc", bus.fault_pc, 32'h1000_0012);
      check("fault_pc_reg", bus.pc_out, 32'h1000_0012);
      step();
      bus.redirect  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("fault_valid", 32'(bus.out_valid), 32'd0);
         check("fault_freeze_pc", bus.pc_out, 32'h1000_0012);
         check("fault_sticky_pc", bus.fault_pc, 32'h1000_0012);
         step();
      end

      // Reset asserted mid-redirect/stall
      bus.redirect        = 1'b1;
      bus.redirect_target = 32'h1000_0020;
      bus.out_ready       = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("arst_pc", bus.pc_out, RESET_PC);
      check("arst_fault", 32'(bus.fetch_fault), 32'd0);
      check("arst_fault_pc", bus.fault_pc, 32'd0);
      check("arst_valid", 32'(bus.out_valid), 32'd0);
      check("arst_fetch_cnt", bus.fetch_count, 32'd0);
      @(posedge clk);
      #1;
      rst           = 1'b0;
      bus.redirect  = 1'b0;
      bus.out_ready = 1'b1;
      push(32'h4000_0000, bios_word(12'd0));
      @(negedge clk);
      check("reboot_valid", 32'(bus.out_valid), 32'd0);
      step();                       // 4000_0000
      step();                       // 4000_0004, flushed
      bus.redirect        = 1'b1;
      bus.redirect_target = 32'h1FFF_FFFC;
      push(32'h1FFF_FFFC, imem_word(14'h3FFF));
      step();
      bus.redirect = 1'b0;
      step();                       // advance runs off the IMEM region
      @(negedge clk);
      check("unmap_fault", 32'(bus.fetch_fault), 32'd1);
      check("unmap_fault_pc", bus.fault_pc, 32'h2000_0000);
      check("unmap_pc", bus.pc_out, 32'h2000_0000);
      check("unmap_valid", 32'(bus.out_valid), 32'd0);

      @(negedge clk);
      check("sb_drain", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Parametrised instruction-fetch front end for the 3-stage RISC-V pipeline; successor to the fixed-width IF stage. Owns the PC and issues fetch addresses to two synchronous-read memories, BIOS and IMEM, selected by address region. It adds a valid/ready handshake with decode, address-hold on stall, a NOP bubble on redirect, and a sticky fetch-fault report for misaligned or unmapped PCs. Memories sit outside the block and are reached through address/data ports.

Parameters:
RESET_PC, 32'h4000_0000, PC loaded on reset.
BIOS_AW, 12, BIOS word-address width, taken from fetch address [BIOS_AW+1:2].
IMEM_AW, 14, IMEM word-address width, taken from fetch address [IMEM_AW+1:2].
BIOS_REGION, 4'h4, fetch address [31:28] value that selects BIOS.
IMEM_REGION, 4'h1, fetch address [31:28] value that selects IMEM.
NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) emitted on flush.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
redirect  in  1  taken branch/jump from EX; flush and load target.
redirect_target  in  32  new PC (ALU result).
out_ready  in  1  decode can accept the instruction.
out_valid  out  1  instruction/pc_out are valid.
instruction  out  32  fetched instruction, or NOP_INST when flushed.
instruction_raw  out  32  memory data before the flush mux.
pc_out  out  32  PC of the presented instruction.
bios_addr  out  BIOS_AW  BIOS read address.
bios_data  in  32  BIOS read data, 1-cycle latency.
imem_addr  out  IMEM_AW  IMEM read address.
imem_data  in  32  IMEM read data, 1-cycle latency.
fetch_fault  out  1  sticky fault flag.
fault_pc  out  32  first faulting address.
fetch_count  out  32  accepted instructions (optional feature).
flush_count  out  32  redirect cycles (optional feature).

Behaviour:
- Reset is asynchronous and active-high; clk is the only clock.
- Reset values: state=BOOT, pc_reg=RESET_PC, src_sel=BIOS, out_valid=0, fetch_fault=0, fault_pc=0, counters=0.
- States:
  - BOOT: lasts exactly 1 cycle after rst deasserts. next_pc=RESET_PC. Always goes to RUN.
  - RUN: out_valid=1 unless redirect or fetch_fault.
- next_pc priority, highest first:
  1. BOOT → RESET_PC.
  2. redirect → redirect_target.
  3. out_valid & out_ready → pc_reg+4, mod 2^32; wrap from FFFF_FFFC to 0 is allowed and then faults as unmapped.
  4. Otherwise → pc_reg (hold).
- Fetch timing:
  - next_pc drives bios_addr/imem_addr combinationally in every state.
  - pc_reg<=next_pc every cycle.
  - src_sel<=region(next_pc).
  - Memory data for pc_reg therefore arrives in the cycle after issue: 1-cycle latency, one instruction per cycle at full throughput.
- Data select: instruction_raw = imem_data if src_sel==IMEM, else bios_data.
- Flush:
  - In any cycle with redirect=1: instruction=NOP_INST and out_valid=0, combinationally.
  - The target instruction is presented the next cycle.
- Stall: out_ready=0 with no redirect re-issues the pc_reg address, so instruction stays stable and out_valid stays 1.
- Redirect during a stall still takes effect immediately.
- Fault detection is on next_pc, and a fault is raised if either condition holds:
  - redirect_target[1:0]!=0 with redirect=1;
  - next_pc[31:28] matches neither region.
- On fault:
  - fetch_fault<=1 and fault_pc<=that address; only the first fault is latched.
  - out_valid is forced to 0 from the next cycle and the PC freezes.
  - Only rst clears the fault.
- rst asserted mid-stall or mid-redirect: immediate return to reset values. The redirect is lost.
- pc_out=pc_reg.

Optional Feature:
IF_PERF_CNT_EN
- Defined: 32-bit wrapping counters are implemented.
  - fetch_count increments on out_valid & out_ready.
  - flush_count increments on each redirect cycle in RUN.
- Undefined: both ports are tied to 0 and no counter flops are inferred.

Test Plan:
- Reset release, BIOS holds 0x00000093 at word 0, out_ready=1: BOOT for 1 cycle, then out_valid=1, pc_out=4000_0000, instruction=0x00000093; pc_out advances by +4 every cycle.
- out_ready=0 for 3 cycles at pc 4000_0008: pc_out, instruction and out_valid are stable, bios_addr=2 held; after release, pc_out=4000_000C the next cycle.
- redirect=1, target=1000_0010: that cycle instruction=NOP_INST and out_valid=0; next cycle pc_out=1000_0010, imem_addr=4 was issued, and instruction is IMEM word 4.
- redirect while out_ready=0: redirect wins, and the target instruction is presented the next cycle.
- redirect target 1000_0012, then 2000_0000: fetch_fault=1, fault_pc=1000_0012 (the second fault is ignored), out_valid=0 until rst.
- IF_PERF_CNT_EN defined, 10 accepts and 2 redirects: fetch_count=10, flush_count=2. Macro undefined: both read 0.
